// File: rtl/e1_tx_buf_fetch_pkg.sv
// Shared E1 buffer definitions: fetch FSM encoding and the buffer RAM address layout
// {mf, frame, ts}, also used by the RX buffer writer and the wishbone buffer port.
package e1_tx_buf_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } e1_buf_state_t;

  localparam int E1_TS_W    = 5;
  localparam int E1_FRAME_W = 4;

  function automatic int buf_aw(input int mfw);
    return mfw + E1_FRAME_W + E1_TS_W;
  endfunction

  // Low part of the buffer word address; the multiframe index sits above it.
  function automatic logic [E1_FRAME_W+E1_TS_W-1:0] buf_addr_lo(
      input logic [E1_FRAME_W-1:0] frame, input logic [E1_TS_W-1:0] ts);
    return {frame, ts};
  endfunction

endpackage

// File: rtl/e1_tx_buf_fetch.sv
// TX buffer fetcher: turns per-timeslot read strobes into arbiter requests, returns the
// byte with a ready flag, shows an idle byte while disabled and counts late strobes.
module e1_tx_buf_fetch
  import e1_tx_buf_fetch_pkg::*;
#(
  parameter int         MFW       = 7,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [7:0]               buf_tx_data,
  input  logic [4:0]               buf_tx_ts,
  input  logic [3:0]               buf_tx_frame,
  input  logic [MFW-1:0]           buf_tx_mf,
  input  logic                     buf_tx_re,
  output logic                     buf_tx_rdy,
  output logic [buf_aw(MFW)-1:0]   mem_addr,
  output logic                     mem_req,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  input  logic                     ctrl_ena,
  input  logic                     stat_late_clr,
  output logic                     stat_late,
  output logic [7:0]               stat_late_cnt
);

  localparam int AW = buf_aw(MFW);

  e1_buf_state_t  state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  shadow_q, shadow_d;
  logic           pend_q, pend_d;
  logic           disc_q, disc_d;
  logic           req_q, req_d;
  logic [7:0]     data_q, data_d;
  logic           rdy_q, rdy_d;
  logic           late_q, late_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  strobe_addr;

  assign strobe_addr = {buf_tx_mf, buf_addr_lo(buf_tx_frame, buf_tx_ts)};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    disc_d   = disc_q;
    data_d   = data_q;
    late_d   = ctrl_ena && buf_tx_re && (state_q == ST_REQ || state_q == ST_WAIT);
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_VALID: begin
        if (ctrl_ena && buf_tx_re) begin
          addr_d  = strobe_addr;
          disc_d  = 1'b0;
          state_d = ST_REQ;
        end else if (!ctrl_ena) begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (late_d) begin
          shadow_d = strobe_addr;
          pend_d   = 1'b1;
        end
        if (mem_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A strobe landing here supersedes both the returning byte and any shadow address.
        if (late_d) begin
          addr_d  = strobe_addr;
          pend_d  = 1'b0;
          disc_d  = 1'b0;
          state_d = ST_REQ;
        end else if (ctrl_ena && pend_q) begin
          addr_d  = shadow_q;
          pend_d  = 1'b0;
          disc_d  = 1'b0;
          state_d = ST_REQ;
        end else if (ctrl_ena && !disc_q) begin
          state_d = ST_VALID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Data fetched for a request issued before a disable is never presented.
    if (!ctrl_ena) begin
      pend_d = 1'b0;
      disc_d = 1'b1;
    end

    req_d = (state_d == ST_REQ);

    if (!ctrl_ena) begin
      data_d = IDLE_BYTE;
      rdy_d  = 1'b1;
    end else begin
      rdy_d = (state_d == ST_VALID);
      if (state_q == ST_WAIT && state_d == ST_VALID) data_d = mem_rdata;
    end

    if (stat_late_clr)                   cnt_d = 8'd0;
    else if (late_d && cnt_q != 8'hFF)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      disc_q   <= 1'b0;
      req_q    <= 1'b0;
      data_q   <= IDLE_BYTE;
      rdy_q    <= 1'b0;
      late_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      disc_q   <= disc_d;
      req_q    <= req_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      late_q   <= late_d;
      cnt_q    <= cnt_d;
    end
  end

  assign buf_tx_data   = data_q;
  assign buf_tx_rdy    = rdy_q;
  assign mem_addr      = addr_q;
  assign mem_req       = req_q;
  assign stat_late     = late_q;
  assign stat_late_cnt = cnt_q;

endmodule

// File: tb/tb_e1_tx_buf_fetch.sv
// Bench for e1_tx_buf_fetch: directed strobes against a bench-side RAM/arbiter, with a
// request/supersede model checked every cycle plus hand-computed literal expectations.
module tb_e1_tx_buf_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  buf_tx_data;
  logic [4:0]  buf_tx_ts = '0;
  logic [3:0]  buf_tx_frame = '0;
  logic [6:0]  buf_tx_mf = '0;
  logic        buf_tx_re = 1'b0;
  logic        buf_tx_rdy;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        ctrl_ena = 1'b0;
  logic        stat_late_clr = 1'b0;
  logic        stat_late;
  logic [7:0]  stat_late_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  e1_tx_buf_fetch #(.MFW(7), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .buf_tx_data(buf_tx_data), .buf_tx_ts(buf_tx_ts), .buf_tx_frame(buf_tx_frame),
    .buf_tx_mf(buf_tx_mf), .buf_tx_re(buf_tx_re), .buf_tx_rdy(buf_tx_rdy),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ctrl_ena(ctrl_ena), .stat_late_clr(stat_late_clr),
    .stat_late(stat_late), .stat_late_cnt(stat_late_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side buffer RAM and arbiter with a programmable grant delay.
  logic [7:0] ram [0:65535];
  int ack_delay = 0;
  int wait_cnt = 0;
  logic req_s = 1'b0, ack_s = 1'b0;
  logic [15:0] addr_s = '0;

  always @(negedge clk) begin
    req_s  = mem_req;
    ack_s  = mem_ack;
    addr_s = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (req_s && ack_s) mem_rdata = ram[addr_s];
    else                mem_rdata = 8'($urandom);
    if (rst || !mem_req || (req_s && ack_s)) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack = 1'b1;
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Model: the newest enabled strobe wins; a strobe while a fetch is in flight is late and
  // is served once the in-flight byte returns; data is shown only for the newest strobe.
  logic        m_req, m_ret, m_want, m_fresh, m_rdy, m_late, m_en_prev;
  logic [15:0] m_addr, m_want_addr;
  logic [7:0]  m_data, m_cnt;

  always @(posedge clk or posedge rst) begin
    logic [15:0] a;
    logic late_now, ret_now, ack_now;
    if (rst) begin
      m_req = 0; m_ret = 0; m_want = 0; m_fresh = 0; m_rdy = 0; m_late = 0;
      m_en_prev = 0; m_addr = '0; m_want_addr = '0; m_data = 8'hFF; m_cnt = '0;
    end else begin
      a = {buf_tx_mf, buf_tx_frame, buf_tx_ts};
      late_now = 0;
      ret_now = m_ret;
      ack_now = m_req && mem_ack;
      if (!ctrl_ena) begin
        m_want = 0; m_fresh = 0; m_rdy = 1; m_data = 8'hFF;
      end else if (!m_en_prev) begin
        m_rdy = 0;
      end
      if (ctrl_ena && buf_tx_re) begin
        if (m_req || ret_now) begin
          late_now = 1; m_want = 1; m_want_addr = a;
        end else begin
          m_req = 1; m_addr = a; m_rdy = 0; m_fresh = 1;
        end
      end
      if (ack_now) m_req = 0;
      m_ret = ack_now;
      if (ret_now && ctrl_ena) begin
        if (m_want) begin
          m_req = 1; m_addr = m_want_addr; m_rdy = 0; m_fresh = 1; m_want = 0;
        end else if (m_fresh) begin
          m_rdy = 1; m_data = mem_rdata;
        end
      end
      m_late = late_now;
      if (stat_late_clr)                  m_cnt = 0;
      else if (late_now && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_en_prev = ctrl_ena;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rdy", 32'(buf_tx_rdy), 32'(m_rdy));
      check("data", 32'(buf_tx_data), 32'(m_data));
      check("mem_req", 32'(mem_req), 32'(m_req));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("stat_late", 32'(stat_late), 32'(m_late));
      check("late_cnt", 32'(stat_late_cnt), 32'(m_cnt));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic strobe(input int mf, input int fr, input int ts, input bit clr = 1'b0);
    buf_tx_mf = 7'(mf); buf_tx_frame = 4'(fr); buf_tx_ts = 5'(ts);
    buf_tx_re = 1'b1; stat_late_clr = clr;
    tick();
    buf_tx_re = 1'b0; stat_late_clr = 1'b0;
  endtask

  task automatic wait_rdy(input int max);
    int n = 0;
    @(negedge clk);
    while (!buf_tx_rdy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!buf_tx_rdy) check("rdy_timeout", 32'(buf_tx_rdy), 32'd1);
  endtask

  int req_cycles;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    ram[16'h0A43] = 8'hA5;
    ram[16'h0A44] = 8'h3C;

    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(buf_tx_rdy), 32'd0);
    check("rst_data", 32'(buf_tx_data), 32'hFF);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_cnt", 32'(stat_late_cnt), 32'd0);
    check("rst_late", 32'(stat_late), 32'd0);
    tick(2);
    rst = 1'b0;
    ctrl_ena = 1'b1;
    tick(2);

    // 1: immediate grant, ready three cycles after the strobe
    ack_delay = 0;
    strobe(5, 2, 3);
    @(negedge clk);
    check("t1_addr", 32'(mem_addr), 32'h0A43);
    check("t1_req", 32'(mem_req), 32'd1);
    tick();
    @(negedge clk);
    check("t1_rdy_early", 32'(buf_tx_rdy), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rdy", 32'(buf_tx_rdy), 32'd1);
    check("t1_data", 32'(buf_tx_data), 32'hA5);
    check("t1_cnt", 32'(stat_late_cnt), 32'd0);

    // 2: grant delayed by ten cycles
    ack_delay = 10;
    strobe(9, 7, 17);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      tick();
    end
    check("t2_req_cycles", 32'(req_cycles), 32'd11);
    check("t2_data", 32'(buf_tx_data), 32'(ram[{7'd9, 4'd7, 5'd17}]));

    // 3: second strobe lands while the first is still requested
    ack_delay = 3;
    strobe(5, 2, 3);
    strobe(5, 2, 4);
    wait_rdy(30);
    check("t3_data", 32'(buf_tx_data), 32'h3C);
    check("t3_addr", 32'(mem_addr), 32'h0A44);
    check("t3_cnt", 32'(stat_late_cnt), 32'd1);
    tick();

    // 4: disable while a request is outstanding
    ack_delay = 5;
    strobe(1, 1, 1);
    ctrl_ena = 1'b0;
    tick();
    @(negedge clk);
    check("t4_data", 32'(buf_tx_data), 32'hFF);
    check("t4_rdy", 32'(buf_tx_rdy), 32'd1);
    check("t4_req_held", 32'(mem_req), 32'd1);
    for (int i = 0; i < 6; i++) begin
      strobe(2, 3, i);
      tick(2);
    end
    @(negedge clk);
    check("t4_req_off", 32'(mem_req), 32'd0);
    check("t4_addr", 32'(mem_addr), 32'h0221);
    check("t4_cnt", 32'(stat_late_cnt), 32'd1);
    ctrl_ena = 1'b1;
    tick();
    @(negedge clk);
    check("t4_reena_rdy", 32'(buf_tx_rdy), 32'd0);

    // 5: counter saturation, then clear together with a late event
    ack_delay = 2000;
    strobe(3, 3, 3);
    for (int i = 0; i < 300; i++) begin
      strobe(4, i % 16, i % 32);
      tick();
    end
    @(negedge clk);
    check("t5_sat", 32'(stat_late_cnt), 32'd255);
    strobe(6, 6, 6, 1'b1);
    @(negedge clk);
    check("t5_clr", 32'(stat_late_cnt), 32'd0);
    check("t5_late", 32'(stat_late), 32'd1);
    ack_delay = 0;
    wait_rdy(40);
    check("t5_data", 32'(buf_tx_data), 32'(ram[{7'd6, 4'd6, 5'd6}]));

    // 6: address extremes
    strobe(127, 15, 31);
    @(negedge clk);
    check("t6_max", 32'(mem_addr), 32'hFFFF);
    wait_rdy(20);
    check("t6_max_data", 32'(buf_tx_data), 32'(ram[16'hFFFF]));
    strobe(0, 0, 0);
    @(negedge clk);
    check("t6_zero", 32'(mem_addr), 32'h0000);
    wait_rdy(20);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/e1_tx_buf_fetch.md
Name: e1_tx_buf_fetch

Overview:
Upstream feeder for the E1 TX wishbone submodule's buffer interface (buf_tx_*).
- Converts each per-timeslot read strobe from the TX core into a request on the shared TX buffer RAM arbiter (req/ack).
- Returns the fetched byte with a ready flag.
- Substitutes an idle pattern when disabled.
- Counts late fetches, where the next strobe arrives before the previous fetch has completed.

Parameters:
MFW, 7, multiframe index width; RAM word address width AW = MFW+9.
IDLE_BYTE, 8'hFF, byte presented while disabled.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
buf_tx_data  out  8  byte for the latched address
buf_tx_ts  in  5  timeslot index, sampled on buf_tx_re
buf_tx_frame  in  4  frame index, sampled on buf_tx_re
buf_tx_mf  in  MFW  multiframe index, sampled on buf_tx_re
buf_tx_re  in  1  single-cycle read strobe from the TX core
buf_tx_rdy  out  1  buf_tx_data valid for the last strobed address
mem_addr  out  MFW+9  RAM word address {mf, frame, ts}
mem_req  out  1  read request to the arbiter
mem_ack  in  1  request accepted; mem_rdata valid the following cycle
mem_rdata  in  8  RAM read data
ctrl_ena  in  1  fetch enable
stat_late_clr  in  1  clears the late counter
stat_late  out  1  one-cycle pulse per late event
stat_late_cnt  out  8  saturating count of late events

Behaviour:
Reset values:
- buf_tx_data = IDLE_BYTE, buf_tx_rdy = 0.
- mem_req = 0, mem_addr = 0.
- stat_late = 0, stat_late_cnt = 0.
- State IDLE, pending flag = 0.

States:
- IDLE: no data yet; rdy = 0.
- REQ: mem_req = 1.
- WAIT: capture mem_rdata.
- VALID: rdy = 1.

Transitions with ctrl_ena = 1:
- re in IDLE or VALID: latch {mf, frame, ts} into mem_addr; next state REQ; rdy drops the next cycle.
- REQ: hold mem_req and mem_addr stable until the cycle mem_ack = 1; next state WAIT; mem_req = 0 from the next cycle.
- WAIT: buf_tx_data <= mem_rdata.
  - If pending = 0: next state VALID, rdy = 1.
  - If pending = 1: discard the data, load the shadow address into mem_addr, clear pending, next state REQ.
- re in REQ or WAIT: late event.
  - Latch the address into the shadow register and set pending.
  - stat_late pulses for 1 cycle and the counter increments.
  - mem_addr never changes while mem_req = 1.
  - A further re while pending overwrites the shadow address and counts again.
- re in the same cycle as mem_ack: counts as late (state is REQ).

Latency:
- re at cycle 0 gives mem_req = 1 at cycle 1.
- mem_ack at cycle k gives rdy = 1 and valid data at cycle k+2.
- With an immediate ack (k = 1), rdy rises at cycle 3.

Disable (ctrl_ena = 0):
- buf_tx_data = IDLE_BYTE and rdy = 1 from the next cycle; re is ignored; pending is cleared.
- An outstanding REQ keeps mem_req high until ack, then WAIT discards the data; no new requests are issued.
- On re-enable: state IDLE, rdy = 0 until the first strobe completes.

Late counter:
- 8-bit, saturates at 255.
- stat_late_clr has priority over a simultaneous increment (result 0).

Decomposition:
- Shared E1 package holds:
  - the state encoding constants (IDLE, REQ, WAIT, VALID);
  - the buffer address width function (MFW+9);
  - the address packing order {mf, frame, ts}, shared with the RX buffer writer and the wishbone buffer port.
- Single flat module; no sub-module is warranted. The saturating counter is inline.

Test Plan:
1. Reset, then ctrl_ena = 1; re with ts = 3, frame = 2, mf = 5; ack on the first req cycle, mem_rdata = 8'hA5 -> mem_addr = {7'd5, 4'd2, 5'd3} = 16'h0A43; rdy = 1 and data = A5 three cycles after re; stat_late_cnt = 0.
2. Arbiter delays ack by 10 cycles -> mem_req held and mem_addr stable for all 10 cycles; rdy = 0 throughout; data valid 2 cycles after ack.
3. Second re (ts = 4) arrives during REQ of ts = 3 -> stat_late pulses once; ts = 3 data is never shown; mem_addr becomes the ts = 4 address after the first ack; final data = byte for ts = 4; cnt = 1.
4. ctrl_ena dropped while in REQ -> buf_tx_data = FF and rdy = 1 next cycle; mem_req stays high until ack, then 0; no further requests despite re strobes.
5. 300 late events, then stat_late_clr asserted together with a late event -> cnt reads 255 before the clear and 0 after it.
6. Address wrap: mf = 127, frame = 15, ts = 31 -> mem_addr = all ones (16'hFFFF); the next strobe with mf = 0, frame = 0, ts = 0 gives mem_addr = 0.
